pc_gen: RTL and testbench

- Parametrised fetch program-counter generator; next generation of the core PC.
- Drives the instruction-fetch address through a valid/ready handshake.
- Supports stall, branch/jump redirect, trap entry, debug halt/resume, optional compressed (2-byte) stepping and misaligned-target detection.
- Sits between the control/execute stages (redirect sources) and instruction memory (fetch address consumer).

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_align_chk.sv | 22 ++
 rtl/pc_gen.sv | 118 +++++++++++
 tb/tb_pc_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int STEP_FULL = 4;
    localparam int STEP_HALF = 2;

    // Address bits that must be zero for a legal instruction target.
    function automatic logic [1:0] align_mask(input int c_ext);
        return (c_ext != 0) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_align_chk.sv
// Target alignment check and trap-vector masking.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module pc_align_chk
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int C_EXT = 0
) (
    input  logic [1:0]      target_lsb,
    input  logic [XLEN-1:0] tvec,
    output logic            misaligned,
    output logic [XLEN-1:0] trap_target
);

    logic tvec_lsb_unused;

    assign misaligned      = |(target_lsb & align_mask(C_EXT));
    assign trap_target     = {tvec[XLEN-1:2], 2'b00};
    assign tvec_lsb_unused = ^tvec[1:0];

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run/halt sequencing with trap, redirect and misalign capture.
// Latency: state, pc and flags update one edge after sampling; pc_seq is combinational.
// Backpressure: pc holds while if_ready is low or stall is high; trap and redirect bypass both.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              C_EXT        = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_ready,
    input  logic            stall,
    input  logic            is_compressed,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] mtvec,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic            if_valid,
    output logic [XLEN-1:0] pc_seq,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_nxt, bad_addr_nxt;
    logic            valid_nxt, misalign_nxt;
    logic            tgt_mis;
    logic [XLEN-1:0] trap_pc, redir_pc;

    pc_align_chk #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_align_chk (
        .target_lsb  (redirect_pc[1:0]),
        .tvec        (mtvec),
        .misaligned  (tgt_mis),
        .trap_target (trap_pc)
    );

    // A misaligned redirect turns into a trap entry.
    assign redir_pc = tgt_mis ? trap_pc : redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            if_valid <= 1'b0;
            misalign <= 1'b0;
            bad_addr <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            if_valid <= valid_nxt;
            misalign <= misalign_nxt;
            bad_addr <= bad_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        valid_nxt    = if_valid;
        misalign_nxt = 1'b0;
        bad_addr_nxt = bad_addr;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                valid_nxt = 1'b1;
            end
            RUN: begin
                if (trap_en) begin
                    pc_nxt    = trap_pc;
                    valid_nxt = 1'b1;
                end else if (redirect_en) begin
                    pc_nxt       = redir_pc;
                    valid_nxt    = 1'b1;
                    misalign_nxt = tgt_mis;
                    if (tgt_mis) bad_addr_nxt = redirect_pc;
                end else if (halt_req) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else if (if_valid && if_ready && !stall) begin
                    pc_nxt = pc_seq;
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
                if (trap_en) begin
                    pc_nxt = trap_pc;
                end else if (redirect_en) begin
                    pc_nxt       = redir_pc;
                    misalign_nxt = tgt_mis;
                    if (tgt_mis) bad_addr_nxt = redirect_pc;
                end
                if (resume && !halt_req) begin
                    state_nxt = RUN;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = BOOT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_seq = pc + ((C_EXT != 0 && is_compressed) ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL));
        halted = (state == HALT);
    end

endmodule

// File: tb/tb_pc_gen.sv
// Drives a 2-byte-capable and a 4-byte-only pc_gen in lockstep against an abstract fetch model.
module tb_pc_gen;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n, if_ready, stall, is_compressed, redirect_en, trap_en, halt_req, resume;
    logic [31:0] redirect_pc, mtvec;

    logic [31:0] pc_o[2], pc_seq_o[2], bad_o[2];
    logic        valid_o[2], halted_o[2], mis_o[2];

    int          m_mode[2], n_mode[2];
    logic [31:0] m_pc[2], n_pc[2], m_bad[2], n_bad[2];
    logic        m_valid[2], n_valid[2], m_mis[2], n_mis[2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance g has C_EXT = g.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(g)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .if_ready      (if_ready),
            .stall         (stall),
            .is_compressed (is_compressed),
            .redirect_en   (redirect_en),
            .redirect_pc   (redirect_pc),
            .trap_en       (trap_en),
            .mtvec         (mtvec),
            .halt_req      (halt_req),
            .resume        (resume),
            .pc            (pc_o[g]),
            .if_valid      (valid_o[g]),
            .pc_seq        (pc_seq_o[g]),
            .halted        (halted_o[g]),
            .misalign      (mis_o[g]),
            .bad_addr      (bad_o[g])
        );
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[c_ext=%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_BOOT; m_pc[i] = 32'h0; m_valid[i] = 1'b0; m_mis[i] = 1'b0; m_bad[i] = 32'h0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("pc", i, pc_o[i], m_pc[i]);
            chk("if_valid", i, 32'(valid_o[i]), 32'(m_valid[i]));
            chk("halted", i, 32'(halted_o[i]), 32'(m_mode[i] == M_HALT));
            chk("misalign", i, 32'(mis_o[i]), 32'(m_mis[i]));
            chk("bad_addr", i, bad_o[i], m_bad[i]);
        end
    endtask

    // Next-cycle behaviour written from the fetch rules: alignment by modulus, vector by rounding down.
    task automatic model_next(input int i);
        int unsigned align;
        logic [31:0] trap_t, tgt;
        bit          bad;
        align  = (i == 1) ? 2 : 4;
        trap_t = (mtvec / 4) * 4;
        bad    = (redirect_pc % align) != 0;
        tgt    = bad ? trap_t : redirect_pc;
        n_mode[i] = m_mode[i]; n_pc[i] = m_pc[i]; n_valid[i] = m_valid[i];
        n_mis[i] = 1'b0; n_bad[i] = m_bad[i];
        if (m_mode[i] == M_BOOT) begin
            n_mode[i] = M_RUN; n_valid[i] = 1'b1;
        end else if (m_mode[i] == M_RUN) begin
            if (trap_en) begin
                n_pc[i] = trap_t; n_valid[i] = 1'b1;
            end else if (redirect_en) begin
                n_pc[i] = tgt; n_valid[i] = 1'b1; n_mis[i] = bad;
                if (bad) n_bad[i] = redirect_pc;
            end else if (halt_req) begin
                n_mode[i] = M_HALT; n_valid[i] = 1'b0;
            end else if (m_valid[i] && if_ready && !stall) begin
                n_pc[i] = m_pc[i] + ((i == 1 && is_compressed) ? 32'd2 : 32'd4);
            end
        end else begin
            n_valid[i] = 1'b0;
            if (trap_en) n_pc[i] = trap_t;
            else if (redirect_en) begin
                n_pc[i] = tgt; n_mis[i] = bad;
                if (bad) n_bad[i] = redirect_pc;
            end
            if (resume && !halt_req) begin
                n_mode[i] = M_RUN; n_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("pc_seq", i, pc_seq_o[i], m_pc[i] + ((i == 1 && is_compressed) ? 32'd2 : 32'd4));
            model_next(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = n_mode[i]; m_pc[i] = n_pc[i]; m_valid[i] = n_valid[i];
            m_mis[i] = n_mis[i]; m_bad[i] = n_bad[i];
        end
        check_all();
    endtask

    task automatic idle_inputs();
        stall = 0; is_compressed = 0; redirect_en = 0; redirect_pc = 0;
        trap_en = 0; mtvec = 0; halt_req = 0; resume = 0;
    endtask

    initial begin
        rst_n = 1'b0; if_ready = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // Boot cycle, then sequential stepping.
        tick();
        chk("boot_valid", 0, 32'(valid_o[0]), 32'd1);
        repeat (4) tick();
        chk("step_pc", 0, pc_o[0], 32'h10);

        stall = 1;
        repeat (3) tick();
        chk("stall_hold", 0, pc_o[0], 32'h10);
        redirect_en = 1; redirect_pc = 32'h200;
        tick();
        chk("redir_stall", 1, pc_o[1], 32'h200);
        stall = 0;

        trap_en = 1; redirect_pc = 32'h300; mtvec = 32'h1003;
        tick();
        chk("trap_wins", 0, pc_o[0], 32'h1000);
        trap_en = 0; redirect_pc = 32'h402;
        tick();
        chk("mis_pc", 0, pc_o[0], 32'h1000);
        chk("mis_pulse", 0, 32'(mis_o[0]), 32'd1);
        chk("mis_bad", 0, bad_o[0], 32'h402);
        chk("c_pc", 1, pc_o[1], 32'h402);
        redirect_en = 0; is_compressed = 1;
        tick();
        chk("c_step", 1, pc_o[1], 32'h404);
        chk("mis_drop", 0, 32'(mis_o[0]), 32'd0);
        is_compressed = 0;

        redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 0;
        tick();
        chk("wrap", 0, pc_o[0], 32'h0);

        redirect_en = 1; redirect_pc = 32'h20;
        tick();
        redirect_en = 0; halt_req = 1;
        tick();
        chk("halt_flag", 0, 32'(halted_o[0]), 32'd1);
        chk("halt_pc", 0, pc_o[0], 32'h20);
        redirect_en = 1; redirect_pc = 32'h80;
        tick();
        chk("halt_write", 0, pc_o[0], 32'h80);
        redirect_en = 0; resume = 1;
        tick();
        chk("resume_blocked", 0, 32'(halted_o[0]), 32'd1);
        halt_req = 0;
        tick();
        chk("resume_valid", 0, 32'(valid_o[0]), 32'd1);
        resume = 0;
        tick();
        chk("resume_step", 0, pc_o[0], 32'h84);

        // Randomised phase with a mid-operation reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #2 rst_n = 1'b1;
            end
            if_ready      = ($urandom_range(3) != 0);
            stall         = ($urandom_range(3) == 0);
            is_compressed = $urandom_range(1) != 0;
            trap_en       = ($urandom_range(15) == 0);
            redirect_en   = ($urandom_range(5) == 0);
            redirect_pc   = $urandom;
            mtvec         = $urandom;
            if ($urandom_range(9) == 0) halt_req = ~halt_req;
            resume        = ($urandom_range(7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
